// File: rtl/snd_arb_pkg.sv
// Shared types and widths for the sound RAM bus arbiter.
package snd_arb_pkg;

    localparam int SND_ADDR_W = 16;
    localparam int SND_DATA_W = 8;

    typedef enum logic [1:0] {
        RST_HOLD,
        Z80_RUN,
        BUS_REQ,
        HOST_OWN
    } arb_state_t;

endpackage

// File: rtl/snd_bus_arbiter_if.sv
// Host, Z80 and sound RAM signals seen by the arbiter; slave = arbiter side.
interface snd_bus_arbiter_if;
    import snd_arb_pkg::*;

    logic                  host_brq;
    logic [SND_ADDR_W-1:0] host_addr;
    logic [SND_DATA_W-1:0] host_din;
    logic                  host_wr;
    logic                  host_rd;
    logic [SND_DATA_W-1:0] host_dout;
    logic                  host_dout_valid;
    logic                  host_grant;
    logic                  host_err;
    logic                  timeout_flag;

    logic [SND_ADDR_W-1:0] z80_addr;
    logic [SND_DATA_W-1:0] z80_dout;
    logic                  z80_mreq_n;
    logic                  z80_wr_n;
    logic                  z80_busak_n;
    logic                  z80_busrq_n;
    logic                  z80_reset_n;
    logic [SND_DATA_W-1:0] z80_ram_dout;

    logic [SND_ADDR_W-1:0] ram_addr;
    logic [SND_DATA_W-1:0] ram_data;
    logic                  ram_we;
    logic [SND_DATA_W-1:0] ram_q;

    modport slave (
        input  host_brq, host_addr, host_din, host_wr, host_rd,
        input  z80_addr, z80_dout, z80_mreq_n, z80_wr_n, z80_busak_n,
        input  ram_q,
        output host_dout, host_dout_valid, host_grant, host_err, timeout_flag,
        output z80_busrq_n, z80_reset_n, z80_ram_dout,
        output ram_addr, ram_data, ram_we
    );

    modport master (
        output host_brq, host_addr, host_din, host_wr, host_rd,
        output z80_addr, z80_dout, z80_mreq_n, z80_wr_n, z80_busak_n,
        output ram_q,
        input  host_dout, host_dout_valid, host_grant, host_err, timeout_flag,
        input  z80_busrq_n, z80_reset_n, z80_ram_dout,
        input  ram_addr, ram_data, ram_we
    );

endinterface

// File: rtl/snd_bus_arbiter.sv
// Shares the 64 KB sound RAM between the sound Z80 and the host upload path,
// holding the Z80 in reset while the host owns the RAM.
module snd_bus_arbiter
    import snd_arb_pkg::*;
#(
    parameter int unsigned RESET_HOLD    = 4,
    parameter int unsigned BUSAK_TIMEOUT = 255
) (
    input  logic              CLK_32M,
    input  logic              reset,
    snd_bus_arbiter_if.slave  bus
);

    localparam logic [7:0]  HOLD_INIT = 8'(RESET_HOLD);
    localparam logic [15:0] TO_LAST   = 16'(BUSAK_TIMEOUT - 1);

    arb_state_t state, state_nxt;
    logic [7:0]  hold_cnt, hold_cnt_nxt;
    logic [15:0] to_cnt, to_cnt_nxt;
    logic        timeout_q, timeout_nxt;
    logic        rst_n_q, rst_n_nxt;

    logic                  rd_pend;
    logic [SND_DATA_W-1:0] dout_q;
    logic                  dout_valid_q;
    logic                  err_q;

    logic host_own;
    logic z80_mux;

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            state     <= RST_HOLD;
            hold_cnt  <= HOLD_INIT;
            to_cnt    <= '0;
            timeout_q <= 1'b0;
            rst_n_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            to_cnt    <= to_cnt_nxt;
            timeout_q <= timeout_nxt;
            rst_n_q   <= rst_n_nxt;
        end
    end

    // Z80 reset is a registered level: BUS_REQ keeps whatever the previous
    // state had, so a request raised during RST_HOLD never releases the Z80.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        to_cnt_nxt   = to_cnt;
        timeout_nxt  = timeout_q;
        rst_n_nxt    = rst_n_q;
        unique case (state)
            RST_HOLD: begin
                if (bus.host_brq) begin
                    state_nxt  = BUS_REQ;
                    to_cnt_nxt = '0;
                end else if (hold_cnt <= 8'd1) begin
                    state_nxt    = Z80_RUN;
                    hold_cnt_nxt = '0;
                    rst_n_nxt    = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt - 8'd1;
                end
            end
            Z80_RUN: begin
                if (bus.host_brq) begin
                    state_nxt  = BUS_REQ;
                    to_cnt_nxt = '0;
                end
            end
            BUS_REQ: begin
                if (!bus.host_brq) begin
                    state_nxt = Z80_RUN;
                    rst_n_nxt = 1'b1;
                end else if (!bus.z80_busak_n) begin
                    state_nxt   = HOST_OWN;
                    timeout_nxt = 1'b0;
                    rst_n_nxt   = 1'b0;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt   = HOST_OWN;
                    timeout_nxt = 1'b1;
                    rst_n_nxt   = 1'b0;
                end else begin
                    to_cnt_nxt = to_cnt + 16'd1;
                end
            end
            HOST_OWN: begin
                if (!bus.host_brq) begin
                    state_nxt    = RST_HOLD;
                    hold_cnt_nxt = HOLD_INIT;
                end
            end
            default: state_nxt = RST_HOLD;
        endcase
    end

    assign host_own = (state == HOST_OWN);
    assign z80_mux  = (state == Z80_RUN) || (state == BUS_REQ);

    // A read accepted on the last granted cycle still completes its pulse.
    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            rd_pend      <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rd_pend      <= bus.host_rd && host_own;
            dout_valid_q <= rd_pend;
            if (rd_pend)
                dout_q <= bus.ram_q;
            if ((bus.host_rd || bus.host_wr) && !host_own)
                err_q <= 1'b1;
        end
    end

    assign bus.ram_addr = host_own ? bus.host_addr : bus.z80_addr;
    assign bus.ram_data = host_own ? bus.host_din  : bus.z80_dout;
    assign bus.ram_we   = host_own ? bus.host_wr
                        : (z80_mux && !bus.z80_mreq_n && !bus.z80_wr_n);

    assign bus.z80_ram_dout    = bus.ram_q;
    assign bus.z80_reset_n     = rst_n_q;
    assign bus.z80_busrq_n     = !((state == BUS_REQ) || host_own);
    assign bus.host_grant      = host_own;
    assign bus.host_dout       = dout_q;
    assign bus.host_dout_valid = dout_valid_q;
    assign bus.host_err        = err_q;
    assign bus.timeout_flag    = timeout_q;

endmodule

// File: tb/tb_snd_bus_arbiter.sv
// Directed and randomized checks of snd_bus_arbiter against a memory/queue
// reference model of the host and Z80 views of the sound RAM.
module tb_snd_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;

    snd_bus_arbiter_if bus();

    snd_bus_arbiter #(.RESET_HOLD(4), .BUSAK_TIMEOUT(8)) dut (
        .CLK_32M (clk),
        .reset   (rst),
        .bus     (bus.slave)
    );

    // Sound RAM: synchronous read, old data on read-during-write.
    bit [7:0] mem [65536];
    always @(posedge clk) begin
        if (bus.ram_we)
            mem[bus.ram_addr] <= bus.ram_data;
        bus.ram_q <= mem[bus.ram_addr];
    end

    typedef struct {
        int unsigned due;
        logic [7:0]  data;
    } rd_exp_t;

    rd_exp_t     rq[$];
    bit [7:0]    ref_mem [65536];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    // A host read issued at cycle c must surface exactly at cycle c+2.
    task automatic check_read_pipe();
        if (rq.size() > 0 && rq[0].due == cyc) begin
            check("rd_valid", bus.host_dout_valid, 1);
            check("rd_data", bus.host_dout, rq[0].data);
            void'(rq.pop_front());
        end else begin
            check("rd_idle", bus.host_dout_valid, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        logic [15:0] a;
        logic [7:0]  d, exp_z;
        bit          rd, wr, have_exp;

        rst = 1'b0;
        bus.host_brq = 0; bus.host_addr = '0; bus.host_din = '0;
        bus.host_wr = 0; bus.host_rd = 0;
        bus.z80_addr = '0; bus.z80_dout = '0;
        bus.z80_mreq_n = 1; bus.z80_wr_n = 1; bus.z80_busak_n = 1;
        #1 rst = 1'b1;
        #2;
        check("rst_reset_n", bus.z80_reset_n, 0);
        check("rst_busrq_n", bus.z80_busrq_n, 1);
        check("rst_grant", bus.host_grant, 0);
        check("rst_dout", bus.host_dout, 0);
        check("rst_valid", bus.host_dout_valid, 0);
        check("rst_err", bus.host_err, 0);
        check("rst_timeout", bus.timeout_flag, 0);
        check("rst_we", bus.ram_we, 0);
        tick(); tick();
        check("rst_hold_in_reset", bus.z80_reset_n, 0);
        rst = 1'b0;

        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (!bus.z80_reset_n) n++;
            tick();
        end
        check("hold_len", n, 4);
        check("run_reset_n", bus.z80_reset_n, 1);
        check("run_busrq_n", bus.z80_busrq_n, 1);

        // Normal takeover via BUSAK
        bus.host_brq = 1;
        tick();
        check("req_busrq_n", bus.z80_busrq_n, 0);
        check("req_grant", bus.host_grant, 0);
        check("req_reset_n", bus.z80_reset_n, 1);
        tick(); tick();
        bus.z80_busak_n = 0;
        check("req_grant_wait", bus.host_grant, 0);
        tick();
        check("own_grant", bus.host_grant, 1);
        check("own_timeout", bus.timeout_flag, 0);
        check("own_reset_n", bus.z80_reset_n, 0);
        check("own_busrq_n", bus.z80_busrq_n, 0);

        // Z80 strobes must not reach the RAM while the host owns it
        bus.z80_mreq_n = 0; bus.z80_wr_n = 0;
        bus.z80_addr = 16'h1234; bus.z80_dout = 8'hEE;
        #1 check("z80_ignored", bus.ram_we, 0);
        bus.host_addr = 16'h1234; bus.host_din = 8'h5A; bus.host_wr = 1;
        #1;
        check("hwr_we", bus.ram_we, 1);
        check("hwr_addr", bus.ram_addr, 16'h1234);
        check("hwr_data", bus.ram_data, 8'h5A);
        tick();
        ref_mem[16'h1234] = 8'h5A;
        bus.z80_mreq_n = 1; bus.z80_wr_n = 1;
        bus.host_wr = 0; bus.host_rd = 1;
        tick();
        bus.host_rd = 0;
        check("hrd_n1", bus.host_dout_valid, 0);
        tick();
        check("hrd_n2_valid", bus.host_dout_valid, 1);
        check("hrd_n2_data", bus.host_dout, 8'h5A);
        tick();
        check("hrd_n3_valid", bus.host_dout_valid, 0);

        // Randomized host traffic while granted
        for (int i = 0; i < 150; i++) begin
            check_read_pipe();
            a  = 16'($urandom_range(0, 15)) | ($urandom_range(0, 1) != 0 ? 16'hFF00 : 16'h0000);
            d  = 8'($urandom);
            rd = ($urandom_range(0, 1) != 0);
            wr = ($urandom_range(0, 2) == 0);
            bus.host_addr = a; bus.host_din = d;
            bus.host_rd = rd; bus.host_wr = wr;
            if (rd) rq.push_back('{cyc + 2, ref_mem[a]});
            if (wr) ref_mem[a] = d;
            tick();
        end
        bus.host_rd = 0; bus.host_wr = 0;
        for (int i = 0; i < 3; i++) begin
            check_read_pipe();
            tick();
        end
        check("rq_drained", rq.size(), 0);

        // Read issued in the cycle host_brq drops still completes
        bus.host_addr = 16'h1234; bus.host_rd = 1;
        bus.host_brq = 0; bus.z80_busak_n = 1;
        exp_z = ref_mem[16'h1234];
        tick();
        bus.host_rd = 0;
        check("drop_grant", bus.host_grant, 0);
        check("drop_reset_n", bus.z80_reset_n, 0);
        check("drop_valid_n1", bus.host_dout_valid, 0);
        tick();
        check("drop_valid_n2", bus.host_dout_valid, 1);
        check("drop_data", bus.host_dout, exp_z);
        n = 0;
        while (!bus.z80_reset_n && n < 20) begin tick(); n++; end
        check("rehold_len", n, 3);

        // Forced takeover by timeout
        bus.host_brq = 1;
        tick();
        check("to_busrq_n", bus.z80_busrq_n, 0);
        n = 0;
        while (!bus.host_grant && n < 20) begin tick(); n++; end
        check("to_cycles", n, 8);
        check("to_flag", bus.timeout_flag, 1);
        check("to_reset_n", bus.z80_reset_n, 0);
        bus.host_brq = 0;
        n = 0;
        while (!bus.z80_reset_n && n < 20) begin tick(); n++; end
        check("to_rerun", bus.z80_reset_n, 1);
        check("to_flag_sticky", bus.timeout_flag, 1);

        // Short request abandoned before BUSAK
        bus.host_brq = 1;
        tick();
        check("pulse_busrq_n", bus.z80_busrq_n, 0);
        check("pulse_reset_n1", bus.z80_reset_n, 1);
        tick();
        bus.host_brq = 0;
        check("pulse_reset_n2", bus.z80_reset_n, 1);
        tick();
        check("pulse_busrq_back", bus.z80_busrq_n, 1);
        check("pulse_reset_n3", bus.z80_reset_n, 1);
        check("pulse_grant", bus.host_grant, 0);
        bus.z80_addr = 16'h0010; bus.z80_dout = 8'h77;
        bus.z80_mreq_n = 0; bus.z80_wr_n = 0;
        #1;
        check("zwr_we", bus.ram_we, 1);
        check("zwr_addr", bus.ram_addr, 16'h0010);
        check("zwr_data", bus.ram_data, 8'h77);
        tick();
        ref_mem[16'h0010] = 8'h77;
        bus.z80_wr_n = 1;
        tick();
        check("zrd_data", bus.z80_ram_dout, 8'h77);

        // Randomized Z80 traffic: write only when both strobes are low
        have_exp = 0;
        for (int i = 0; i < 100; i++) begin
            if (have_exp) check("z80_rd", bus.z80_ram_dout, exp_z);
            a = 16'($urandom_range(0, 31));
            d = 8'($urandom);
            bus.z80_addr = a; bus.z80_dout = d;
            bus.z80_mreq_n = ($urandom_range(0, 3) == 0);
            bus.z80_wr_n   = ($urandom_range(0, 1) != 0);
            exp_z = ref_mem[a];
            have_exp = 1;
            if (!bus.z80_mreq_n && !bus.z80_wr_n) ref_mem[a] = d;
            tick();
        end
        check("z80_rd_last", bus.z80_ram_dout, exp_z);
        check("err_clean", bus.host_err, 0);

        // Host access while not granted is dropped and flagged
        bus.z80_mreq_n = 1; bus.z80_wr_n = 1;
        bus.host_addr = 16'h0000; bus.host_din = 8'hA5; bus.host_wr = 1;
        #1 check("nogrant_we", bus.ram_we, 0);
        tick();
        bus.host_wr = 0;
        check("nogrant_err", bus.host_err, 1);
        bus.host_rd = 1;
        tick();
        bus.host_rd = 0;
        tick();
        check("nogrant_rd_valid", bus.host_dout_valid, 0);
        bus.z80_addr = 16'h0000; bus.z80_mreq_n = 0;
        tick(); tick();
        check("nogrant_mem", bus.z80_ram_dout, ref_mem[16'h0000]);
        bus.z80_mreq_n = 1;
        for (int i = 0; i < 5; i++) tick();
        check("err_sticky", bus.host_err, 1);

        // Async reset with a read in flight
        bus.host_brq = 1; bus.z80_busak_n = 0;
        tick(); tick();
        check("ar_grant", bus.host_grant, 1);
        bus.host_addr = 16'h0010; bus.host_rd = 1;
        tick();
        bus.host_rd = 0;
        #3 rst = 1'b1;
        #1;
        check("ar_valid", bus.host_dout_valid, 0);
        check("ar_err", bus.host_err, 0);
        check("ar_grant_off", bus.host_grant, 0);
        check("ar_reset_n", bus.z80_reset_n, 0);
        check("ar_busrq_n", bus.z80_busrq_n, 1);
        check("ar_dout", bus.host_dout, 0);
        tick();
        check("ar_valid_held", bus.host_dout_valid, 0);
        bus.host_brq = 0; bus.z80_busak_n = 1;
        rst = 1'b0;
        tick();
        check("ar_valid_after", bus.host_dout_valid, 0);
        check("ar_we", bus.ram_we, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
